// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl
//   Initiator-side sequencer for a small 4-bit RAM. In verify mode it writes
//   addr^SEED to every word, then reads each word back and flags mismatches.
//   In scan mode it only reads the words and streams them out on rdata.
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   start        in   one-cycle run request, ignored while busy
//   sw           in   mode at start: 0 = verify, 1 = scan
//   waddr/din/we out  RAM write port (waddr/din hold when we=0)
//   raddr        out  RAM read address (holds last address when not reading)
//   dout         in   RAM read data, RD_LAT cycles after raddr
//   busy         out  run in progress
//   done         out  one-cycle pulse at the end of a run
//   rdata        out  last word captured from dout
//   rdata_valid  out  one-cycle pulse when rdata is new
//   err          out  sticky mismatch flag (verify mode), cleared at start
//   err_addr     out  address of the first mismatch
//   err_cnt      out  mismatch count, saturating at 31
module ram_seq_ctrl #(
  parameter int         DEPTH     = 16,
  parameter logic [3:0] SEED      = 4'hF,
  parameter int         RD_LAT    = 1,
  parameter int         STEP_LOG2 = 0
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       start,
  input  logic       sw,
  output logic [3:0] waddr,
  output logic [3:0] din,
  output logic       we,
  output logic [3:0] raddr,
  input  logic [3:0] dout,
  output logic       busy,
  output logic       done,
  output logic [3:0] rdata,
  output logic       rdata_valid,
  output logic       err,
  output logic [3:0] err_addr,
  output logic [4:0] err_cnt
);

  localparam int DATA_W = 4;
  localparam int DIV_W  = (STEP_LOG2 > 0) ? STEP_LOG2 : 1;

  localparam logic [DATA_W-1:0] LAST     = DATA_W'(DEPTH - 1);
  localparam logic [DIV_W-1:0]  DIV_TOP  = DIV_W'((1 << STEP_LOG2) - 1);
  localparam logic [1:0]        LAT_INIT = 2'(RD_LAT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic              mode;
  logic [DATA_W-1:0] addr;
  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        lat_cnt;
  logic [DATA_W-1:0] waddr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] raddr_q;
  logic              tick;
  logic              vld_p0;
  logic              mism_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1;

  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] a);
    return a ^ SEED;
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  always_comb begin
    tick    = (STEP_LOG2 == 0) ? 1'b1 : (div_cnt == DIV_TOP);
    we      = (state == S_WRITE) && tick;
    waddr   = we ? addr : waddr_q;
    din     = we ? pattern(addr) : din_q;
    raddr   = (state == S_READ || state == S_WAIT) ? addr : raddr_q;
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    // stage p0: dout is valid on the last latency cycle of WAIT
    vld_p0  = (state == S_WAIT) && (lat_cnt == 2'd1);
    mism_p0 = vld_p0 && !mode && (dout != pattern(addr));
  end

  assign rdata       = rdata_p1;
  assign rdata_valid = vld_p1;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state    <= S_IDLE;
      mode     <= 1'b0;
      addr     <= '0;
      div_cnt  <= '0;
      lat_cnt  <= '0;
      waddr_q  <= '0;
      din_q    <= '0;
      raddr_q  <= '0;
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      err      <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      // stage p1: captured word and its one-cycle valid
      vld_p1  <= vld_p0;
      if (vld_p0)
        rdata_p1 <= dout;
      if (we) begin
        waddr_q <= addr;
        din_q   <= pattern(addr);
      end
      if (state == S_READ || state == S_WAIT)
        raddr_q <= addr;
      if (mism_p0) begin
        err     <= 1'b1;
        err_cnt <= sat_inc(err_cnt);
        if (!err)
          err_addr <= addr;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            mode     <= sw;
            err      <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
            addr     <= '0;
            div_cnt  <= '0;
            state    <= sw ? S_READ : S_WRITE;
          end
        end
        S_WRITE: begin
          if (tick) begin
            if (addr == LAST) begin
              addr  <= '0;
              state <= S_READ;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        S_READ: begin
          if (tick) begin
            lat_cnt <= LAT_INIT;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 2'd1;
          if (lat_cnt == 2'd1) begin
            if (addr == LAST) begin
              state <= S_DONE;
            end else begin
              addr  <= addr + 1'b1;
              state <= S_READ;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb_ram_seq_ctrl
//   Two sequencer instances, each on its own behavioural RAM:
//     dut0: DEPTH=16 SEED=F RD_LAT=1 STEP_LOG2=0
//     dut1: DEPTH=4  SEED=5 RD_LAT=2 STEP_LOG2=2
//   The RAM models can force chosen words to read a fixed value.
module tb_ram_seq_ctrl;

  localparam int         DEP0 = 16, DEP1 = 4;
  localparam logic [3:0] SEED0 = 4'hF, SEED1 = 4'h5;
  localparam int         RL0 = 1, RL1 = 2;
  localparam int         ST0 = 0, ST1 = 2;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic       rst;
  logic       start [2];
  logic       sw [2];
  logic       we [2];
  logic       busy [2];
  logic       done [2];
  logic       rdata_valid [2];
  logic       err [2];
  logic [3:0] waddr [2];
  logic [3:0] din [2];
  logic [3:0] raddr [2];
  logic [3:0] dout [2];
  logic [3:0] rdata [2];
  logic [3:0] err_addr [2];
  logic [4:0] err_cnt [2];

  ram_seq_ctrl #(.DEPTH(DEP0), .SEED(SEED0), .RD_LAT(RL0), .STEP_LOG2(ST0)) dut0 (
    .CLOCK_50(CLOCK_50), .rst(rst), .start(start[0]), .sw(sw[0]),
    .waddr(waddr[0]), .din(din[0]), .we(we[0]), .raddr(raddr[0]), .dout(dout[0]),
    .busy(busy[0]), .done(done[0]), .rdata(rdata[0]), .rdata_valid(rdata_valid[0]),
    .err(err[0]), .err_addr(err_addr[0]), .err_cnt(err_cnt[0]));

  ram_seq_ctrl #(.DEPTH(DEP1), .SEED(SEED1), .RD_LAT(RL1), .STEP_LOG2(ST1)) dut1 (
    .CLOCK_50(CLOCK_50), .rst(rst), .start(start[1]), .sw(sw[1]),
    .waddr(waddr[1]), .din(din[1]), .we(we[1]), .raddr(raddr[1]), .dout(dout[1]),
    .busy(busy[1]), .done(done[1]), .rdata(rdata[1]), .rdata_valid(rdata_valid[1]),
    .err(err[1]), .err_addr(err_addr[1]), .err_cnt(err_cnt[1]));

  function automatic int dep(input int u);  return (u != 0) ? DEP1 : DEP0; endfunction
  function automatic logic [3:0] seed(input int u); return (u != 0) ? SEED1 : SEED0; endfunction
  function automatic int rl(input int u);   return (u != 0) ? RL1 : RL0; endfunction
  function automatic int st(input int u);   return (u != 0) ? ST1 : ST0; endfunction

  // Behavioural RAMs with read latency and per-word forced read values
  logic [3:0] mem [2][16];
  logic [3:0] pre [2][16];
  logic       load [2];
  logic       f_en [2][16];
  logic [3:0] f_val [2][16];
  logic [3:0] pipe [2][3];

  always @(posedge CLOCK_50) begin
    for (int u = 0; u < 2; u++) begin
      if (load[u]) begin
        for (int a = 0; a < 16; a++) mem[u][a] <= pre[u][a];
      end else if (we[u]) begin
        mem[u][waddr[u]] <= din[u];
      end
      pipe[u][0] <= f_en[u][raddr[u]] ? f_val[u][raddr[u]] : mem[u][raddr[u]];
      pipe[u][1] <= pipe[u][0];
      pipe[u][2] <= pipe[u][1];
    end
  end
  assign dout[0] = pipe[0][RL0-1];
  assign dout[1] = pipe[1][RL1-1];

  // Event monitor: absolute cycle stamps of writes, read pulses and done pulses
  typedef struct {
    int         u;
    int         c;
    logic [3:0] a;
    logic [3:0] d;
  } ev_t;
  ev_t wq[$];
  ev_t rq[$];
  ev_t dq[$];
  int  cyc_ctr = 0;

  always @(posedge CLOCK_50) cyc_ctr <= cyc_ctr + 1;

  always @(negedge CLOCK_50) begin
    for (int u = 0; u < 2; u++) begin
      if (we[u] === 1'b1)          wq.push_back(ev_t'{u, cyc_ctr, waddr[u], din[u]});
      if (rdata_valid[u] === 1'b1) rq.push_back(ev_t'{u, cyc_ctr, 4'h0, rdata[u]});
      if (done[u] === 1'b1)        dq.push_back(ev_t'{u, cyc_ctr, 4'h0, 4'h0});
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [31:0] outv(input int u);
    return {2'b00, we[u], waddr[u], din[u], raddr[u], busy[u], done[u], rdata[u],
            rdata_valid[u], err[u], err_addr[u], err_cnt[u]};
  endfunction

  // Per-run bookkeeping
  int         r_base, r_ws, r_rs, r_ds, r_done;
  logic [3:0] snap [16];

  task automatic clear_forces();
    for (int u = 0; u < 2; u++)
      for (int a = 0; a < 16; a++) begin
        f_en[u][a]  = 1'b0;
        f_val[u][a] = 4'h0;
      end
  endtask

  task automatic preload(input int u);
    @(negedge CLOCK_50);
    load[u] = 1'b1;
    @(negedge CLOCK_50);
    load[u] = 1'b0;
  endtask

  task automatic do_run(input int u, input logic mode, input int extra_at);
    int k;
    for (int a = 0; a < 16; a++) snap[a] = mem[u][a];
    r_ws = wq.size();
    r_rs = rq.size();
    r_ds = dq.size();
    @(negedge CLOCK_50);
    start[u] = 1'b1;
    sw[u]    = mode;
    r_base   = cyc_ctr;
    @(negedge CLOCK_50);
    start[u] = 1'b0;
    sw[u]    = 1'($urandom);
    k = 1;
    while (done[u] !== 1'b1 && k < 400) begin
      if (k == extra_at) start[u] = 1'b1;
      @(negedge CLOCK_50);
      start[u] = 1'b0;
      k++;
    end
    r_done = (done[u] === 1'b1) ? k : -1;
    @(negedge CLOCK_50);
    chk("busy_after_run", busy[u], 0);
  endtask

  // Reference: event timing from the tick rule, data from the RAM contents
  task automatic check_model(input int u, input logic mode);
    int         p, c, nw, nr, ecnt;
    logic       e;
    logic [3:0] ea, av, v;
    p = 1 << st(u);
    c = 1; nw = 0; nr = 0; ecnt = 0; e = 1'b0; ea = 4'h0;
    if (!mode) begin
      for (int a = 0; a < dep(u); a++) begin
        while (c % p != 0) c++;
        av = 4'(a);
        if (r_ws + nw < wq.size()) begin
          chk("wr_cycle", wq[r_ws+nw].c - r_base, c);
          chk("wr_addr", wq[r_ws+nw].a, av);
          chk("wr_data", wq[r_ws+nw].d, av ^ seed(u));
        end
        nw++;
        c++;
      end
    end
    chk("wr_count", wq.size() - r_ws, nw);
    for (int a = 0; a < dep(u); a++) begin
      while (c % p != 0) c++;
      c = c + rl(u) + 1;
      av = 4'(a);
      if (f_en[u][a])  v = f_val[u][a];
      else if (!mode)  v = av ^ seed(u);
      else             v = snap[a];
      if (r_rs + nr < rq.size()) begin
        chk("rd_cycle", rq[r_rs+nr].c - r_base, c);
        chk("rd_data", rq[r_rs+nr].d, v);
      end
      nr++;
      if (!mode && v != (av ^ seed(u))) begin
        if (!e) ea = av;
        e = 1'b1;
        ecnt++;
      end
    end
    chk("rd_count", rq.size() - r_rs, nr);
    chk("done_cycle", r_done, c);
    chk("done_pulses", dq.size() - r_ds, 1);
    chk("err", err[u], e);
    chk("err_addr", err_addr[u], ea);
    chk("err_cnt", err_cnt[u], (ecnt > 31) ? 31 : ecnt);
  endtask

  typedef struct {
    int         u;
    logic       mode;
    int         fa;
    logic [3:0] fv;
    logic       e;
    logic [3:0] ea;
    int         ec;
    int         dn;
    int         nrd;
    int         nwr;
  } vec_t;
  vec_t tbl [7];

  initial begin
    int found;
    tbl[0] = '{0, 1'b0, -1, 4'h0, 1'b0, 4'h0,  0, 49, 16, 16};
    tbl[1] = '{0, 1'b0,  2, 4'h7, 1'b1, 4'h2,  1, 49, 16, 16};
    tbl[2] = '{0, 1'b0,  5, 4'hA, 1'b0, 4'h0,  0, 49, 16, 16};
    tbl[3] = '{0, 1'b0, 15, 4'hF, 1'b1, 4'hF,  1, 49, 16, 16};
    tbl[4] = '{0, 1'b1,  2, 4'h7, 1'b0, 4'h0,  0, 33, 16,  0};
    tbl[5] = '{1, 1'b0, -1, 4'h0, 1'b0, 4'h0,  0, 35,  4,  4};
    tbl[6] = '{1, 1'b0,  3, 4'h3, 1'b1, 4'h3,  1, 35,  4,  4};

    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0;
      sw[u]    = 1'b0;
      load[u]  = 1'b0;
      for (int a = 0; a < 16; a++) pre[u][a] = 4'($urandom);
    end
    clear_forces();
    preload(0);
    preload(1);
    repeat (2) @(negedge CLOCK_50);
    chk("reset_outs_dut0", outv(0), 0);
    chk("reset_outs_dut1", outv(1), 0);
    rst = 1'b0;

    // Table-driven runs
    for (int i = 0; i < 7; i++) begin
      clear_forces();
      if (tbl[i].fa >= 0) begin
        f_en[tbl[i].u][tbl[i].fa]  = 1'b1;
        f_val[tbl[i].u][tbl[i].fa] = tbl[i].fv;
      end
      do_run(tbl[i].u, tbl[i].mode, 0);
      chk("tbl_done_cycle", r_done, tbl[i].dn);
      chk("tbl_err", err[tbl[i].u], tbl[i].e);
      chk("tbl_err_addr", err_addr[tbl[i].u], tbl[i].ea);
      chk("tbl_err_cnt", err_cnt[tbl[i].u], tbl[i].ec);
      chk("tbl_rd_count", rq.size() - r_rs, tbl[i].nrd);
      chk("tbl_wr_count", wq.size() - r_ws, tbl[i].nwr);
      check_model(tbl[i].u, tbl[i].mode);
    end

    // Scan of a preloaded RAM: first words F,3,7 and no writes
    clear_forces();
    pre[0][0] = 4'hF; pre[0][1] = 4'h3; pre[0][2] = 4'h7;
    preload(0);
    do_run(0, 1'b1, 0);
    if (rq.size() >= r_rs + 3) begin
      chk("scan_word0", rq[r_rs].d, 4'hF);
      chk("scan_word1", rq[r_rs+1].d, 4'h3);
      chk("scan_word2", rq[r_rs+2].d, 4'h7);
    end else begin
      chk("scan_word_count", rq.size() - r_rs, 16);
    end
    chk("scan_no_we", wq.size() - r_ws, 0);
    check_model(0, 1'b1);

    // start pulsed mid-run is ignored: single done at the normal cycle
    do_run(0, 1'b0, 5);
    repeat (60) @(negedge CLOCK_50);
    check_model(0, 1'b0);
    do_run(1, 1'b1, 9);
    repeat (40) @(negedge CLOCK_50);
    check_model(1, 1'b1);

    // Reset during WRITE at addr 6, together with a start request
    @(negedge CLOCK_50);
    start[0] = 1'b1;
    sw[0]    = 1'b0;
    @(negedge CLOCK_50);
    start[0] = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      if (we[0] === 1'b1 && waddr[0] === 4'd6) found = 1;
      else @(negedge CLOCK_50);
    end
    chk("reach_addr6", found, 1);
    rst      = 1'b1;
    start[0] = 1'b1;
    @(negedge CLOCK_50);
    chk("midrun_rst_outs", outv(0), 0);
    start[0] = 1'b0;
    rst      = 1'b0;
    @(negedge CLOCK_50);
    chk("midrun_rst_idle", busy[0], 0);
    do_run(0, 1'b0, 0);
    check_model(0, 1'b0);

    // Randomized runs against the reference
    for (int i = 0; i < 12; i++) begin
      int   u;
      logic mode;
      u    = int'($urandom_range(0, 1));
      mode = 1'($urandom);
      clear_forces();
      for (int a = 0; a < 16; a++) begin
        pre[u][a] = 4'($urandom);
        if ($urandom_range(0, 5) == 0) begin
          f_en[u][a]  = 1'b1;
          f_val[u][a] = 4'($urandom);
        end
      end
      if ($urandom_range(0, 1) == 1) preload(u);
      do_run(u, mode, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0);
      check_model(u, mode);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
